// File: rtl/bram_line_master.sv
// Purpose : turns one line-wide read/write request into a byte-serial burst on a
//           single-port synchronous-read byte RAM, returning the whole line on reads.
// Latency : accept at edge 0 -> write response in cycle LINE_BYTES+1,
//           read response in cycle LINE_BYTES+2.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-low reset
//   req_valid/req_ready      line request handshake (req_write, req_addr, req_wdata)
//   rsp_valid/rsp_ready      completion handshake, rsp_rdata carries the read line
//   ram_addr/ram_din/ram_wen registered byte-RAM command; ram_dout is one cycle late
//
// Build option: define BRAM_LINE_MASTER_WRAP_EN for critical-byte-first read bursts.
module bram_line_master #(
    parameter int LINE_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [7:0]              req_addr,
    input  logic [8*LINE_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*LINE_BYTES-1:0] rsp_rdata,
    output logic [7:0]              ram_addr,
    output logic [7:0]              ram_din,
    output logic                    ram_wen,
    input  logic [7:0]              ram_dout
);

    localparam int OFF_W = $clog2(LINE_BYTES);

`ifdef BRAM_LINE_MASTER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, RESP} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [OFF_W-1:0]           beat;
    logic [OFF_W-1:0]           beat_nxt;
    logic                       last_beat;
    logic [LINE_BYTES-1:0][7:0] wdata_q;
    logic [LINE_BYTES-1:0][7:0] rdata_q;
    logic                       cap_vld;
    logic [OFF_W-1:0]           cap_lane;
    logic [OFF_W-1:0]           req_off;
    logic [OFF_W-1:0]           first_off;
    logic [OFF_W-1:0]           next_off;

    assign last_beat = (beat == OFF_W'(LINE_BYTES - 1));
    assign beat_nxt  = beat + OFF_W'(1);
    assign req_off   = req_addr[OFF_W-1:0];
    // Writes always start at the line base; reads start at the requested byte
    // only in the wrapping build.
    assign first_off = (WRAP && !req_write) ? req_off : '0;
    // Offset arithmetic is confined to OFF_W bits so a burst wraps inside the
    // line instead of carrying into the line address.
    assign next_off  = ram_addr[OFF_W-1:0] + OFF_W'(1);
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_nxt = RESP;
                end
            end
            READ: begin
                if (last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cap_vld  <= 1'b0;
            cap_lane <= '0;
            ram_addr <= 8'h00;
            ram_din  <= 8'h00;
            ram_wen  <= 1'b0;
        end else begin
            // Read data for the address shown in cycle n appears in cycle n+1 and
            // is captured at its end, so the lane is delayed one cycle to match.
            cap_vld  <= (state == READ);
            cap_lane <= ram_addr[OFF_W-1:0];
            if (cap_vld) begin
                rdata_q[cap_lane] <= ram_dout;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        beat     <= '0;
                        wdata_q  <= req_wdata;
                        ram_addr <= {req_addr[7:OFF_W], first_off};
                        if (req_write) begin
                            ram_wen <= 1'b1;
                            ram_din <= req_wdata[7:0];
                        end
                    end
                end
                WRITE, READ: begin
                    if (last_beat) begin
                        beat    <= '0;
                        ram_wen <= 1'b0;
                    end else begin
                        beat     <= beat_nxt;
                        ram_addr <= {ram_addr[7:OFF_W], next_off};
                        if (state == WRITE) begin
                            ram_din <= wdata_q[beat_nxt];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_line_master.sv
module tb_bram_line_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wen;
    logic [7:0]  ram_dout = 8'h00;

    logic [7:0]  mem [256] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    bram_line_master #(.LINE_BYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_wen   (ram_wen),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read byte RAM
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write transaction including response consumption.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [31:0] keep_rdata);
        logic [7:0] base;
        logic [7:0] b;
        base = addr & 8'hFC;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = data[8*i +: 8];
            chk("wr_wen", ram_wen, 1'b1);
            chk("wr_addr", ram_addr, base + 8'(i));
            chk("wr_din", ram_din, b);
            chk("wr_rsp_early", rsp_valid, 1'b0);
            tick();
        end
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_wen_off", ram_wen, 1'b0);
        chk("wr_addr_hold", ram_addr, base + 8'd3);
        chk("wr_rdata_keep", rsp_rdata, keep_rdata);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_idle_rdy", req_ready, 1'b1);
        chk("wr_idle_rsp", rsp_valid, 1'b0);
    endtask

    // Read transaction; returns with the DUT sitting in RESP (cycle 6).
    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data);
        logic [7:0] base;
        logic [1:0] off;
        base = addr & 8'hFC;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef BRAM_LINE_MASTER_WRAP_EN
            off = 2'(addr[1:0] + 2'(i));
`else
            off = 2'(i);
`endif
            chk("rd_addr", ram_addr, base | {6'b0, off});
            chk("rd_wen", ram_wen, 1'b0);
            chk("rd_rsp_early", rsp_valid, 1'b0);
            chk("rd_req_rdy", req_ready, 1'b0);
            tick();
        end
        chk("rd_drain_rsp", rsp_valid, 1'b0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rdata", rsp_rdata, exp_data);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_ram_wen", ram_wen, 1'b0);
        chk("rst_ram_addr", ram_addr, 8'h00);
        chk("rst_ram_din", ram_din, 8'h00);
        chk("rst_rdata", rsp_rdata, 32'h0);
        #11 rst = 1'b1;
        tick();

        // Aligned line write, then its RAM contents
        do_write(8'h10, 32'hDDCCBBAA, 32'h0);
        chk("mem_10", mem[8'h10], 8'hAA);
        chk("mem_13", mem[8'h13], 8'hDD);

        // Read from mid-line, then a stalled response
        do_read(8'h12, 32'hDDCCBBAA);
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40;
            tick();
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_rdata", rsp_rdata, 32'hDDCCBBAA);
            chk("stall_req_ready", req_ready, 1'b0);
            chk("stall_wen", ram_wen, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_idle", req_ready, 1'b1);
        chk("consume_rsp", rsp_valid, 1'b0);
        chk("consume_no_accept_wen", ram_wen, 1'b0);
`ifdef BRAM_LINE_MASTER_WRAP_EN
        chk("consume_addr_hold", ram_addr, 8'h11);
`else
        chk("consume_addr_hold", ram_addr, 8'h13);
`endif
        req_valid = 1'b0;
        tick();

        // Reset in the middle of a write burst
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 32'h44332211;
        tick();
        req_valid = 1'b0;
        chk("rw_b0_addr", ram_addr, 8'h20);
        tick();
        chk("rw_b1_addr", ram_addr, 8'h21);
        tick();
        chk("rw_b2_wen", ram_wen, 1'b1);
        #3 rst = 1'b0;
        #1;
        chk("rw_abort_wen", ram_wen, 1'b0);
        chk("rw_abort_addr", ram_addr, 8'h00);
        chk("rw_abort_rdy", req_ready, 1'b1);
        chk("rw_abort_rdata", rsp_rdata, 32'h0);
        #2 rst = 1'b1;
        tick();
        chk("rw_after_rdy", req_ready, 1'b1);
        chk("rw_after_rsp", rsp_valid, 1'b0);
        chk("rw_after_wen", ram_wen, 1'b0);
        tick();
        chk("rw_mem_20", mem[8'h20], 8'h11);
        chk("rw_mem_21", mem[8'h21], 8'h22);
        chk("rw_mem_22", mem[8'h22], 8'h00);
        chk("rw_mem_23", mem[8'h23], 8'h00);

        // Top-of-memory line: unaligned write, read at 0xFE, no carry out
        do_write(8'hFD, 32'h87654321, 32'h0);
        do_read(8'hFE, 32'h87654321);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("top_idle", req_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
